// File: rtl/edf_deadline_tracker.sv
// Per-queue relative-deadline tracker for the EDF scheduler: counts each non-empty queue's
// deadline down from its programmed period, reloads on consume and flags/counts overruns.
module edf_deadline_tracker #(
  parameter int NB_QUEUES      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MISS_CNT_WIDTH = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                cfg_valid,
  input  logic [$clog2(NB_QUEUES)-1:0]        cfg_id,
  input  logic [DATA_WIDTH-1:0]               cfg_period,
  output logic                                cfg_ready,
  input  logic [NB_QUEUES-1:0]                empty,
  input  logic [NB_QUEUES-1:0]                consumed,
  output logic [NB_QUEUES*DATA_WIDTH-1:0]     deadlines,
  output logic [NB_QUEUES*DATA_WIDTH-1:0]     periods,
  output logic [NB_QUEUES-1:0]                missed,
  output logic [NB_QUEUES*MISS_CNT_WIDTH-1:0] miss_count,
  output logic                                miss_irq
);

  localparam int ID_W = $clog2(NB_QUEUES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_MISSED = 2'd2;

  logic                      cfg_ready_q, cfg_ready_d;
  logic                      cfg_accept;
  logic [DATA_WIDTH-1:0]     period_q   [NB_QUEUES];
  logic [DATA_WIDTH-1:0]     period_d   [NB_QUEUES];
  logic [DATA_WIDTH-1:0]     deadline_q [NB_QUEUES];
  logic [DATA_WIDTH-1:0]     deadline_d [NB_QUEUES];
  logic [1:0]                state_q    [NB_QUEUES];
  logic [1:0]                state_d    [NB_QUEUES];
  logic [MISS_CNT_WIDTH-1:0] miss_cnt_q [NB_QUEUES];
  logic [MISS_CNT_WIDTH-1:0] miss_cnt_d [NB_QUEUES];
  logic                      miss_irq_q, miss_irq_d;

  // Writes to ids with no matching queue are accepted but match no slot, so they vanish.
  always_comb begin
    cfg_accept  = cfg_valid && cfg_ready_q;
    cfg_ready_d = !cfg_accept;
    for (int i = 0; i < NB_QUEUES; i++) begin
      period_d[i] = period_q[i];
      if (cfg_accept && (cfg_id == ID_W'(i))) begin
        period_d[i] = cfg_period;
      end
    end
  end

  always_comb begin
    miss_irq_d = 1'b0;
    for (int i = 0; i < NB_QUEUES; i++) begin
      state_d[i]    = state_q[i];
      deadline_d[i] = deadline_q[i];
      miss_cnt_d[i] = miss_cnt_q[i];
      if (enable) begin
        case (state_q[i])
          ST_IDLE: begin
            deadline_d[i] = period_q[i];
            if (!empty[i] && (period_q[i] != '0)) begin
              state_d[i] = ST_ARMED;
            end
          end
          // A zero period disables the queue outright, ahead of consume or expiry.
          ST_ARMED: begin
            if (period_q[i] == '0) begin
              state_d[i]    = ST_IDLE;
              deadline_d[i] = '0;
            end else if (consumed[i]) begin
              deadline_d[i] = period_q[i];
              if (empty[i]) begin
                state_d[i] = ST_IDLE;
              end
            end else if (deadline_q[i] > DATA_WIDTH'(1)) begin
              deadline_d[i] = deadline_q[i] - DATA_WIDTH'(1);
            end else begin
              state_d[i]    = ST_MISSED;
              deadline_d[i] = '0;
              miss_irq_d    = 1'b1;
              if (miss_cnt_q[i] != '1) begin
                miss_cnt_d[i] = miss_cnt_q[i] + MISS_CNT_WIDTH'(1);
              end
            end
          end
          ST_MISSED: begin
            if (period_q[i] == '0) begin
              state_d[i]    = ST_IDLE;
              deadline_d[i] = '0;
            end else if (consumed[i]) begin
              deadline_d[i] = period_q[i];
              state_d[i]    = empty[i] ? ST_IDLE : ST_ARMED;
            end else if (empty[i]) begin
              deadline_d[i] = period_q[i];
              state_d[i]    = ST_IDLE;
            end
          end
          default: begin
            state_d[i]    = ST_IDLE;
            deadline_d[i] = period_q[i];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_ready_q <= 1'b1;
      miss_irq_q  <= 1'b0;
      for (int i = 0; i < NB_QUEUES; i++) begin
        period_q[i]   <= '0;
        deadline_q[i] <= '0;
        state_q[i]    <= ST_IDLE;
        miss_cnt_q[i] <= '0;
      end
    end else begin
      cfg_ready_q <= cfg_ready_d;
      miss_irq_q  <= miss_irq_d;
      for (int i = 0; i < NB_QUEUES; i++) begin
        period_q[i]   <= period_d[i];
        deadline_q[i] <= deadline_d[i];
        state_q[i]    <= state_d[i];
        miss_cnt_q[i] <= miss_cnt_d[i];
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign miss_irq  = miss_irq_q;

  for (genvar g = 0; g < NB_QUEUES; g++) begin : g_out
    assign deadlines[g*DATA_WIDTH +: DATA_WIDTH]          = deadline_q[g];
    assign periods[g*DATA_WIDTH +: DATA_WIDTH]            = period_q[g];
    assign missed[g]                                      = (state_q[g] == ST_MISSED);
    assign miss_count[g*MISS_CNT_WIDTH +: MISS_CNT_WIDTH] = miss_cnt_q[g];
  end

endmodule
